clock_select_ctrl: RTL and testbench
====================================

# clock_select_ctrl

Controls which clock the CPU runs on, sitting on the request side of the HS/LS clock switch. It decodes each CPU cycle's host-access flag and drives the switch's `select_hs` request. It waits for the switch's `selected_hs`/`selected_ls` status handshake and holds the CPU with RDY while a handover is in flight. It keeps the CPU on the LS (host 2 MHz) clock for a programmable dwell after the last host access, so back-to-back host cycles do not thrash the switch.

## Interface
- `DWELL_CYCLES`, default 4: number of idle LS cycles after the last host access before returning to HS; 0 means return on the first idle cycle.
- `DWELL_W`, default 4: width of the dwell counter; must satisfy DWELL_CYCLES < 2^DWELL_W.
- `ck_ip`  in  1  switched CPU clock (the switch output); all state updates on posedge.
- `resetb`  in  1  reset, asynchronous, active-low.
- `host_access_ip`  in  1  current CPU cycle targets host memory/IO; valid at posedge ck_ip.
- `force_ls_ip`  in  1  level; while 1 the CPU must run on LS (turbo off).
- `selected_hs_ip`  in  1  switch status: HS clock confirmed.
- `selected_ls_ip`  in  1  switch status: LS clock confirmed.
- `select_hs_op`  out  1  request to switch: 1 = HS, 0 = LS.
- `rdy_op`  out  1  CPU RDY; 0 stalls the current cycle, which the CPU repeats.
- `ls_active_op`  out  1  1 in LS_RUN, i.e. CPU is running host-timed cycles.

## Operation
- FSM states: REQ_LS, LS_RUN, REQ_HS, HS_RUN. All outputs are registered.
- Reset: state REQ_LS, select_hs_op=0, rdy_op=0, ls_active_op=0, dwell counter=DWELL_CYCLES. This matches the switch, which comes out of reset on LS.
- REQ_LS: select_hs_op=0, rdy_op=0.
  - selected_ls_ip=1 → LS_RUN, rdy_op=1, counter=DWELL_CYCLES.
- LS_RUN: select_hs_op=0, rdy_op=1, ls_active_op=1.
  - host_access_ip=1 or force_ls_ip=1 → counter reloads to DWELL_CYCLES.
  - Otherwise, counter==0 → REQ_HS.
  - Otherwise, counter decrements. The counter saturates at 0 and never wraps.
- REQ_HS: select_hs_op=1, rdy_op=0.
  - host_access_ip=1 or force_ls_ip=1 → REQ_LS (aborted handover). This has priority over selected_hs_ip.
  - Otherwise, selected_hs_ip=1 → HS_RUN, rdy_op=1.
- HS_RUN: select_hs_op=1, rdy_op=1.
  - host_access_ip=1 or force_ls_ip=1 → REQ_LS, rdy_op=0. The host cycle is stalled and replays on LS.
  - selected_hs_ip=0 (lost status) → REQ_HS, rdy_op=0.
- Simultaneous host_access_ip and force_ls_ip: identical effect, no conflict.
- Status inputs are ignored outside the REQ states, except for the HS_RUN lost-status check.

## Timing
- Clocking: the controller is clocked by the switched clock, which stops high during a handover. FSM edges therefore resume on the new clock source. No REQ-state counters are used, because they would not advance while the clock is stopped.
- HS→LS:
  - Edge N samples host_access_ip=1 in HS_RUN; select_hs_op and rdy_op fall after edge N.
  - rdy_op returns to 1 on the first edge after selected_ls_ip is sampled 1.
- LS→HS:
  - With no access, the last access at edge N gives REQ_HS entry at edge N+DWELL_CYCLES+1.
  - rdy_op=1 on the first edge after selected_hs_ip=1.
- Reset deassertion: takes effect on the next posedge ck_ip. An asynchronous reset mid-handover returns to REQ_LS immediately, with rdy_op=0.

## Configuration
- `CLOCK_SELECT_CTRL_DWELL_EN`
  - Defined: dwell counter behaves as above.
  - Undefined: the dwell counter and DWELL_CYCLES are unused. LS_RUN moves to REQ_HS on the first cycle with host_access_ip=0 and force_ls_ip=0, equivalent to DWELL_CYCLES=0 with no counter logic.

## Test plan
- Reset, then selected_ls_ip=1 on the 2nd edge → rdy_op=1 and ls_active_op=1 after the 2nd edge. Idle for 5 edges (DWELL_CYCLES=4) → REQ_HS, select_hs_op=1, rdy_op=0.
- HS_RUN, host_access_ip=1 for one edge → select_hs_op=0, rdy_op=0. selected_ls_ip=1 → rdy_op=1 next edge; the replayed access reloads the counter to 4.
- LS_RUN with host accesses every 3rd edge (DWELL_CYCLES=4) → stays in LS_RUN indefinitely, select_hs_op constantly 0.
- REQ_HS with host_access_ip=1 while selected_hs_ip=0 → REQ_LS, select_hs_op=0, rdy_op stays 0 throughout.
- force_ls_ip=1 held for 20 edges with no accesses → remains in LS_RUN. Release → REQ_HS after 5 edges.
- resetb pulsed low while in HS_RUN → outputs immediately select_hs_op=0, rdy_op=0, ls_active_op=0. Repeat the idle-return check with the macro undefined → REQ_HS on the 1st idle edge.

Source files
------------

// File: rtl/clock_select_ctrl_if.sv
// CPU-cycle and clock-switch handshake bundle for clock_select_ctrl.
// master = CPU/switch side, slave = controller side.
interface clock_select_ctrl_if;
  logic host_access_ip;
  logic force_ls_ip;
  logic selected_hs_ip;
  logic selected_ls_ip;
  logic select_hs_op;
  logic rdy_op;
  logic ls_active_op;

  modport master (
    output host_access_ip,
    output force_ls_ip,
    output selected_hs_ip,
    output selected_ls_ip,
    input  select_hs_op,
    input  rdy_op,
    input  ls_active_op
  );

  modport slave (
    input  host_access_ip,
    input  force_ls_ip,
    input  selected_hs_ip,
    input  selected_ls_ip,
    output select_hs_op,
    output rdy_op,
    output ls_active_op
  );
endinterface

// File: rtl/clock_select_ctrl.sv
// HS/LS CPU clock request controller with RDY stall during switch handover.
// Define CLOCK_SELECT_CTRL_DWELL_EN to keep LS for DWELL_CYCLES idle cycles after a host access.
module clock_select_ctrl #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned DWELL_W      = 4
) (
  input  logic                 ck_ip,
  input  logic                 resetb,
  clock_select_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    REQ_LS = 2'd0,
    LS_RUN = 2'd1,
    REQ_HS = 2'd2,
    HS_RUN = 2'd3
  } state_t;

  // Dwell reload value must fit the counter.
  if (DWELL_W < 32 && (DWELL_CYCLES >> DWELL_W) != 0) begin : g_bad_dwell
    $error("clock_select_ctrl: DWELL_CYCLES does not fit in DWELL_W bits");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic r_select_hs;
  logic r_rdy;
  logic r_ls_active;
  logic w_select_hs_nxt;
  logic w_rdy_nxt;
  logic w_ls_active_nxt;

  logic w_want_ls;
  logic w_dwell_done;

  assign w_want_ls = bus.host_access_ip | bus.force_ls_ip;

`ifdef CLOCK_SELECT_CTRL_DWELL_EN
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES);

  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [DWELL_W-1:0] w_dwell_cnt_nxt;

  // Counts idle LS cycles; parked at the reload value outside LS_RUN.
  always_comb begin
    w_dwell_cnt_nxt = DWELL_LOAD;
    if (r_state == LS_RUN && !w_want_ls && r_dwell_cnt != '0) begin
      w_dwell_cnt_nxt = r_dwell_cnt - 1'b1;
    end
  end

  always_ff @(posedge ck_ip or negedge resetb) begin
    if (!resetb) begin
      r_dwell_cnt <= DWELL_LOAD;
    end else begin
      r_dwell_cnt <= w_dwell_cnt_nxt;
    end
  end

  assign w_dwell_done = (r_dwell_cnt == '0);
`else
  assign w_dwell_done = 1'b1;
`endif

  // State and registered outputs; clock stops during handover, so no REQ timeouts.
  always_ff @(posedge ck_ip or negedge resetb) begin
    if (!resetb) begin
      r_state     <= REQ_LS;
      r_select_hs <= 1'b0;
      r_rdy       <= 1'b0;
      r_ls_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_select_hs <= w_select_hs_nxt;
      r_rdy       <= w_rdy_nxt;
      r_ls_active <= w_ls_active_nxt;
    end
  end

  // Host access or turbo-off beats HS confirmation in every state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ_LS: begin
        if (bus.selected_ls_ip) w_state_nxt = LS_RUN;
      end
      LS_RUN: begin
        if (!w_want_ls && w_dwell_done) w_state_nxt = REQ_HS;
      end
      REQ_HS: begin
        if (w_want_ls)               w_state_nxt = REQ_LS;
        else if (bus.selected_hs_ip) w_state_nxt = HS_RUN;
      end
      HS_RUN: begin
        if (w_want_ls)                w_state_nxt = REQ_LS;
        else if (!bus.selected_hs_ip) w_state_nxt = REQ_HS;
      end
      default: w_state_nxt = REQ_LS;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    w_select_hs_nxt = 1'b0;
    w_rdy_nxt       = 1'b0;
    w_ls_active_nxt = 1'b0;
    case (w_state_nxt)
      LS_RUN: begin
        w_rdy_nxt       = 1'b1;
        w_ls_active_nxt = 1'b1;
      end
      REQ_HS: begin
        w_select_hs_nxt = 1'b1;
      end
      HS_RUN: begin
        w_select_hs_nxt = 1'b1;
        w_rdy_nxt       = 1'b1;
      end
      default: begin
        w_select_hs_nxt = 1'b0;
      end
    endcase
  end

  assign bus.select_hs_op = r_select_hs;
  assign bus.rdy_op       = r_rdy;
  assign bus.ls_active_op = r_ls_active;

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Self-checking bench for clock_select_ctrl: vector rows queued to a scoreboard
// and checked after each edge, plus reset sequences.
module tb_clock_select_ctrl;
  localparam int unsigned DWELL_CYCLES = 4;
  localparam int unsigned DWELL_W      = 4;
`ifdef CLOCK_SELECT_CTRL_DWELL_EN
  localparam int unsigned EFF = DWELL_CYCLES;
`else
  localparam int unsigned EFF = 0;
`endif

  typedef enum int {S_REQ_LS, S_LS_RUN, S_REQ_HS, S_HS_RUN} st_e;

  typedef struct {
    logic host;
    logic force_ls;
    logic sel_hs;
    logic sel_ls;
    logic exp_sel_hs;
    logic exp_rdy;
    logic exp_ls;
    int   id;
  } vec_t;

  logic ck_ip;
  logic resetb;
  clock_select_ctrl_if bus();

  clock_select_ctrl #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .DWELL_W      (DWELL_W)
  ) dut (
    .ck_ip  (ck_ip),
    .resetb (resetb),
    .bus    (bus)
  );

  initial ck_ip = 1'b0;
  always #5 ck_ip = ~ck_ip;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests  = 0;
  int   n_failed = 0;
  int   row_id   = 0;

  task automatic check(input string name, input int id, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s row %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  function automatic void add(input logic h, input logic f, input logic shs,
                              input logic sls, input st_e st);
    vec_t v;
    v.host       = h;
    v.force_ls   = f;
    v.sel_hs     = shs;
    v.sel_ls     = sls;
    v.exp_sel_hs = (st == S_REQ_HS) || (st == S_HS_RUN);
    v.exp_rdy    = (st == S_LS_RUN) || (st == S_HS_RUN);
    v.exp_ls     = (st == S_LS_RUN);
    v.id         = row_id;
    row_id++;
    vecs.push_back(v);
  endfunction

  // EFF idle cycles stay on LS, the next idle edge requests HS.
  function automatic void add_idle_to_hs();
    for (int k = 0; k < int'(EFF); k++) add(1'b0, 1'b0, 1'b0, 1'b0, S_LS_RUN);
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_HS);
  endfunction

  // Entered and left at a negedge.
  task automatic run_rows();
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.host_access_ip = vecs[i].host;
      bus.force_ls_ip    = vecs[i].force_ls;
      bus.selected_hs_ip = vecs[i].sel_hs;
      bus.selected_ls_ip = vecs[i].sel_ls;
      sb.push_back(vecs[i]);
      @(posedge ck_ip);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", i, 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("select_hs_op", e.id, bus.select_hs_op, e.exp_sel_hs);
        check("rdy_op",       e.id, bus.rdy_op,       e.exp_rdy);
        check("ls_active_op", e.id, bus.ls_active_op, e.exp_ls);
      end
      @(negedge ck_ip);
    end
    vecs.delete();
  endtask

  initial begin
    int per;
    resetb             = 1'b0;
    bus.host_access_ip = 1'b0;
    bus.force_ls_ip    = 1'b0;
    bus.selected_hs_ip = 1'b0;
    bus.selected_ls_ip = 1'b0;
    #2;
    check("reset_select_hs", -1, bus.select_hs_op, 1'b0);
    check("reset_rdy",       -1, bus.rdy_op,       1'b0);
    check("reset_ls_active", -1, bus.ls_active_op, 1'b0);

    // Power-up to LS, dwell, HS handover, host access back to LS, replay reload.
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add_idle_to_hs();
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_HS);
    add(1'b0, 1'b0, 1'b1, 1'b0, S_HS_RUN);
    add(1'b0, 1'b0, 1'b1, 1'b0, S_HS_RUN);
    add(1'b1, 1'b0, 1'b1, 1'b0, S_REQ_LS);
    add(1'b1, 1'b0, 1'b0, 1'b0, S_REQ_LS);
    add(1'b1, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add(1'b1, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add_idle_to_hs();

    // Abort in REQ_HS wins over a simultaneous HS confirm.
    add(1'b1, 1'b0, 1'b1, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b1, S_LS_RUN);

    // Periodic host accesses faster than the dwell keep LS.
    per = (EFF >= 2) ? 3 : 1;
    for (int i = 0; i < 12; i++)
      add(logic'((i % per) == (per - 1)), 1'b0, 1'b0, 1'b0, S_LS_RUN);

    // Turbo off held, then released.
    for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 1'b0, 1'b0, S_LS_RUN);
    add_idle_to_hs();

    // Lost HS status, abort with no confirm, simultaneous host and force.
    add(1'b0, 1'b0, 1'b1, 1'b0, S_HS_RUN);
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_HS);
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_HS);
    add(1'b1, 1'b0, 1'b0, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add_idle_to_hs();
    add(1'b0, 1'b0, 1'b1, 1'b0, S_HS_RUN);
    add(1'b1, 1'b1, 1'b1, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add_idle_to_hs();
    add(1'b0, 1'b0, 1'b1, 1'b0, S_HS_RUN);

    @(negedge ck_ip);
    resetb = 1'b1;
    run_rows();

    // Asynchronous reset while in HS_RUN clears outputs without a clock edge.
    #2;
    resetb = 1'b0;
    #1;
    check("async_select_hs", -2, bus.select_hs_op, 1'b0);
    check("async_rdy",       -2, bus.rdy_op,       1'b0);
    check("async_ls_active", -2, bus.ls_active_op, 1'b0);

    add(1'b0, 1'b0, 1'b1, 1'b0, S_REQ_LS);
    add(1'b0, 1'b0, 1'b0, 1'b1, S_LS_RUN);
    add_idle_to_hs();
    @(negedge ck_ip);
    resetb = 1'b1;
    run_rows();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
